// File: rtl/odu_pkg.sv
// Shared definitions for the ODU slot scheduler: channel count default,
// FSM state encoding and the per-type rate constants (X step, Y threshold).
package odu_pkg;

   localparam int NUM_CH_DEF = 8;
   localparam int ACC_W_DEF  = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   localparam int unsigned TYPE0_X = 9;
   localparam int unsigned TYPE0_Y = 74984;
   localparam int unsigned TYPE2_X = 7;
   localparam int unsigned TYPE2_Y = 9373;

   // Accumulator increment for a channel rate type (0 = type0, 1 = type2)
   function automatic int unsigned rate_x(input logic typ);
      return typ ? TYPE2_X : TYPE0_X;
   endfunction

   // Grant threshold for a channel rate type
   function automatic int unsigned rate_y(input logic typ);
      return typ ? TYPE2_Y : TYPE0_Y;
   endfunction

endpackage

// File: rtl/odu_rate_step.sv
// One evaluation of a channel's rate accumulator: grant and subtract Y when
// the accumulator has reached the threshold, otherwise add the X step.
module odu_rate_step
   import odu_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic             type_i,
   output logic [ACC_W-1:0] acc_nxt_o,
   output logic             gen_o
);

   logic [ACC_W-1:0] x_c;
   logic [ACC_W-1:0] y_c;

   // Select the rate constants and compute the next accumulator value
   always_comb begin
      x_c   = ACC_W'(rate_x(type_i));
      y_c   = ACC_W'(rate_y(type_i));
      gen_o = (acc_i >= y_c);
      if (gen_o) begin
         acc_nxt_o = acc_i - y_c;
      end else begin
         acc_nxt_o = acc_i + x_c;
      end
   end

endmodule

// File: rtl/odu_slot_scheduler.sv
// ODU slot scheduler: a round-robin slot pointer visits one tributary channel
// per cycle and a shared rate engine decides whether that channel gets a
// data-generation grant. Grants are held (and everything frozen) while the
// downstream is not ready.
module odu_slot_scheduler
   import odu_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int CH_W   = 3,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run_start,
   input  logic            run_stop,
   input  logic            cfg_wr,
   input  logic [CH_W-1:0] cfg_ch,
   input  logic            cfg_en,
   input  logic            cfg_type,
   input  logic            gen_ready,
   output logic            gen_valid,
   output logic [CH_W-1:0] gen_ch,
   output logic            slot_wrap,
   output logic            running
);

   logic [1:0]        state_q, state_d;
   logic              stop_pend_q, stop_pend_d;
   logic [CH_W-1:0]   slot_q;
   logic [ACC_W-1:0]  acc_q [NUM_CH];
   logic [NUM_CH-1:0] en_q;
   logic [NUM_CH-1:0] type_q;
   logic              gen_valid_q;
   logic [CH_W-1:0]   gen_ch_q;
   logic              slot_wrap_q;

   logic              eval;
   logic              gv_clr;
   logic              cfg_hit;
   logic              grant;
   logic [ACC_W-1:0]  step_acc;
   logic              step_gen;

   odu_rate_step #(.ACC_W(ACC_W)) u_step (
      .acc_i     (acc_q[slot_q]),
      .type_i    (type_q[slot_q]),
      .acc_nxt_o (step_acc),
      .gen_o     (step_gen)
   );

   // Run/stall control: a held beat always completes before stopping
   always_comb begin
      state_d     = state_q;
      stop_pend_d = stop_pend_q;
      eval        = 1'b0;
      gv_clr      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run_start && !run_stop) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (gen_valid_q && !gen_ready) begin
               state_d     = ST_STALL;
               stop_pend_d = run_stop;
            end else if (run_stop) begin
               state_d = ST_IDLE;
               gv_clr  = 1'b1;
            end else begin
               eval = 1'b1;
            end
         end
         ST_STALL: begin
            if (run_stop) stop_pend_d = 1'b1;
            if (gen_ready) begin
               gv_clr      = 1'b1;
               stop_pend_d = 1'b0;
               state_d     = (stop_pend_q || run_stop) ? ST_IDLE : ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A configuration write to the slot under evaluation suppresses its grant
   assign cfg_hit = cfg_wr && (cfg_ch == slot_q);
   assign grant   = eval && en_q[slot_q] && !cfg_hit && step_gen;

   // Control state, slot pointer and registered grant outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         stop_pend_q <= 1'b0;
         slot_q      <= '0;
         gen_valid_q <= 1'b0;
         gen_ch_q    <= '0;
         slot_wrap_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         stop_pend_q <= stop_pend_d;
         slot_wrap_q <= eval && (slot_q == CH_W'(NUM_CH - 1));
         if (eval) begin
            gen_valid_q <= grant;
            if (grant) gen_ch_q <= slot_q;
            slot_q <= slot_q + 1'b1;
         end else if (gv_clr) begin
            gen_valid_q <= 1'b0;
         end
      end
   end

   // Per-channel configuration and accumulator update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
         en_q   <= '0;
         type_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_wr && (cfg_ch == CH_W'(i))) begin
               acc_q[i]  <= '0;
               en_q[i]   <= cfg_en;
               type_q[i] <= cfg_type;
            end else if (eval && (slot_q == CH_W'(i)) && en_q[i]) begin
               acc_q[i] <= step_acc;
            end
         end
      end
   end

   assign gen_valid = gen_valid_q;
   assign gen_ch    = gen_ch_q;
   assign slot_wrap = slot_wrap_q;
   assign running   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_odu_slot_scheduler.sv
// Testbench for odu_slot_scheduler: table-driven control vectors, directed
// rate/stall/config/reset sequences and a randomized run, all checked every
// cycle against a behavioural model of the scheduling rules.
module tb_odu_slot_scheduler;

   localparam int NCH = 4;
   localparam int CW  = 2;
   localparam int AW  = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          run_start = 1'b0, run_stop = 1'b0, cfg_wr = 1'b0;
   logic [CW-1:0] cfg_ch = '0;
   logic          cfg_en = 1'b0, cfg_type = 1'b0, gen_ready = 1'b1;
   logic          gen_valid, slot_wrap, running;
   logic [CW-1:0] gen_ch;

   always #5 clk = ~clk;

   odu_slot_scheduler #(.NUM_CH(NCH), .CH_W(CW), .ACC_W(AW)) dut (
      .clk(clk), .rst(rst), .run_start(run_start), .run_stop(run_stop),
      .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_type(cfg_type),
      .gen_ready(gen_ready), .gen_valid(gen_valid), .gen_ch(gen_ch),
      .slot_wrap(slot_wrap), .running(running)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2;
   longint m_acc [NCH];
   bit     m_en  [NCH];
   bit     m_typ [NCH];
   int     m_slot, m_state, m_gch;
   bit     m_gv, m_wrap, m_stop;

   function automatic longint rx(input bit t); return t ? 7 : 9; endfunction
   function automatic longint ry(input bit t); return t ? 9373 : 74984; endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_acc[i] = 0; m_en[i] = 0; m_typ[i] = 0;
      end
      m_slot = 0; m_state = M_IDLE; m_gch = 0;
      m_gv = 0; m_wrap = 0; m_stop = 0;
   endtask

   task automatic model_step();
      bit ev;
      int ch;
      ev = 0;
      case (m_state)
         M_IDLE:  if (run_start && !run_stop) m_state = M_RUN;
         M_RUN: begin
            if (m_gv && !gen_ready) begin m_state = M_STALL; m_stop = run_stop; end
            else if (run_stop) begin m_state = M_IDLE; m_gv = 0; end
            else ev = 1;
         end
         default: begin
            if (run_stop) m_stop = 1;
            if (gen_ready) begin
               m_gv = 0;
               m_state = m_stop ? M_IDLE : M_RUN;
               m_stop = 0;
            end
         end
      endcase
      m_wrap = 0;
      if (ev) begin
         ch = m_slot;
         m_wrap = (ch == NCH - 1);
         m_gv = 0;
         if (!(cfg_wr && int'(cfg_ch) == ch) && m_en[ch]) begin
            if (m_acc[ch] >= ry(m_typ[ch])) begin
               m_acc[ch] -= ry(m_typ[ch]);
               m_gv = 1;
               m_gch = ch;
            end else begin
               m_acc[ch] += rx(m_typ[ch]);
            end
         end
         m_slot = (m_slot + 1) % NCH;
      end
      if (cfg_wr) begin
         m_en[cfg_ch] = cfg_en; m_typ[cfg_ch] = cfg_type; m_acc[cfg_ch] = 0;
      end
   endtask

   function automatic int pk(input logic gv, input int gc, input logic wr, input logic rn);
      return (gv ? 256 : 0) + (gv ? gc * 4 : 0) + (wr ? 2 : 0) + (rn ? 1 : 0);
   endfunction

   // One clock: advance the model, let the DUT take the edge, compare, clear pulses
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check("outputs", pk(gen_valid, int'(gen_ch), slot_wrap, running),
            pk(m_gv, m_gch, m_wrap, m_state != M_IDLE));
      run_start = 0; run_stop = 0; cfg_wr = 0;
   endtask

   task automatic do_reset();
      rst = 1; run_start = 0; run_stop = 0; cfg_wr = 0; gen_ready = 1;
      model_reset();
      @(posedge clk);
      #1;
      check("reset_outputs", pk(gen_valid, int'(gen_ch), slot_wrap, running), 0);
      check("reset_gen_ch", gen_ch, 0);
      rst = 0;
   endtask

   task automatic cfg(input int ch, input bit en, input bit ty);
      cfg_wr = 1; cfg_ch = CW'(ch); cfg_en = en; cfg_type = ty;
      cycle();
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      bit rs; bit rp; bit cw; int cch; bit cen; bit cty;
      bit e_gv; bit e_wr; bit e_run;
   } vec_t;
   vec_t tbl [16];

   int n;

   initial begin
      tbl[0]  = '{0,0,0,0,0,0, 0,0,0};
      tbl[1]  = '{1,0,0,0,0,0, 0,0,1};
      tbl[2]  = '{0,0,0,0,0,0, 0,0,1};
      tbl[3]  = '{0,0,0,0,0,0, 0,0,1};
      tbl[4]  = '{0,0,0,0,0,0, 0,0,1};
      tbl[5]  = '{0,0,0,0,0,0, 0,1,1};
      tbl[6]  = '{1,1,0,0,0,0, 0,0,0};
      tbl[7]  = '{1,1,0,0,0,0, 0,0,0};
      tbl[8]  = '{0,1,0,0,0,0, 0,0,0};
      tbl[9]  = '{1,0,0,0,0,0, 0,0,1};
      tbl[10] = '{0,0,0,0,0,0, 0,0,1};
      tbl[11] = '{0,0,1,1,0,0, 0,0,1};
      tbl[12] = '{0,0,0,0,0,0, 0,0,1};
      tbl[13] = '{0,0,0,0,0,0, 0,1,1};
      tbl[14] = '{0,1,0,0,0,0, 0,0,0};
      tbl[15] = '{0,0,0,0,0,0, 0,0,0};

      do_reset();
      for (int i = 0; i < 16; i++) begin
         run_start = tbl[i].rs; run_stop = tbl[i].rp; cfg_wr = tbl[i].cw;
         cfg_ch = CW'(tbl[i].cch); cfg_en = tbl[i].cen; cfg_type = tbl[i].cty;
         cycle();
         check($sformatf("tbl%0d", i), pk(gen_valid, int'(gen_ch), slot_wrap, running),
               pk(tbl[i].e_gv, 0, tbl[i].e_wr, tbl[i].e_run));
      end

      // ch0 type2: grants at the 1340th and 2680th ch0 evaluation, then stall cases
      do_reset();
      cfg(0, 1, 1);
      run_start = 1; cycle();
      n = 0;
      while (n < 6000) begin cycle(); n++; if (gen_valid) break; end
      check("req037_first_grant_cycle", n, 1 + 4 * 1339);
      check("req037_acc_after_grant", dut.acc_q[0], 0);
      while (n < 10716) begin cycle(); n++; end
      gen_ready = 0;
      cycle(); n++;
      check("req037_second_grant", pk(gen_valid, int'(gen_ch), slot_wrap, running), pk(1, 0, 0, 1));
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("req039_stall_hold", pk(gen_valid, int'(gen_ch), slot_wrap, running), pk(1, 0, 0, 1));
         check("req039_slot_frozen", dut.slot_q, 1);
      end
      gen_ready = 1;
      cycle();
      check("req039_resume", pk(gen_valid, int'(gen_ch), slot_wrap, running), pk(0, 0, 0, 1));

      gen_ready = 0;
      n = 0;
      while (n < 6000) begin cycle(); n++; if (gen_valid) break; end
      check("req041_grant_seen", gen_valid, 1);
      cycle();
      run_stop = 1;
      cycle();
      check("req041_held_after_stop", pk(gen_valid, int'(gen_ch), slot_wrap, running), pk(1, 0, 0, 1));
      cycle();
      gen_ready = 1;
      cycle();
      check("req041_idle_after_beat", pk(gen_valid, int'(gen_ch), slot_wrap, running), 0);

      // ch3 type0: grant at the 8333rd ch3 evaluation leaving acc=4
      do_reset();
      cfg(3, 1, 0);
      run_start = 1; cycle();
      n = 0;
      while (n < 34000) begin cycle(); n++; if (gen_valid) break; end
      check("req038_grant_cycle", n, 4 * 8333);
      check("req038_gen_ch", gen_ch, 3);
      check("req038_acc", dut.acc_q[3], 4);

      // cfg write on ch2's own slot with acc at threshold: no grant, acc cleared
      do_reset();
      cfg(2, 1, 1);
      run_start = 1; cycle();
      n = 0;
      while (n < 5358) begin cycle(); n++; end
      check("req040_acc_at_threshold", dut.acc_q[2], 9373);
      cfg_wr = 1; cfg_ch = 2; cfg_en = 1; cfg_type = 1;
      cycle();
      check("req040_no_grant", gen_valid, 0);
      check("req040_acc_cleared", dut.acc_q[2], 0);

      // reset in the middle of a stall
      gen_ready = 0;
      n = 0;
      while (n < 6000) begin cycle(); n++; if (gen_valid) break; end
      check("req042_grant_seen", gen_valid, 1);
      cycle();
      cycle();
      rst = 1;
      #2;
      check("req042_outputs", pk(gen_valid, int'(gen_ch), slot_wrap, running), 0);
      check("req042_acc", dut.acc_q[2], 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 0;
      gen_ready = 1;

      // randomized run against the model
      do_reset();
      for (int c = 0; c < NCH; c++) cfg(c, 1, 1);
      for (int i = 0; i < 8000; i++) begin
         run_start = ($urandom_range(0, 19) == 0);
         run_stop  = ($urandom_range(0, 299) == 0);
         cfg_wr    = ($urandom_range(0, 999) == 0);
         cfg_ch    = CW'($urandom_range(0, NCH - 1));
         cfg_en    = ($urandom_range(0, 3) != 0);
         cfg_type  = $urandom_range(0, 1) != 0;
         gen_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      for (int c = 0; c < NCH; c++) check($sformatf("rand_acc%0d", c), dut.acc_q[c], m_acc[c]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/odu_slot_scheduler.md
ODU_SLOT_SCHEDULER -- requirements
Module: odu_slot_scheduler

Interface
REQ-001 Parameter NUM_CH, default 8, number of tributary channels sharing the rate engine (power of two).
REQ-002 Parameter CH_W, default 3, channel index width, log2(NUM_CH).
REQ-003 Parameter ACC_W, default 32, per-channel accumulator width.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 run_start  input  1  one-cycle pulse; begins slot scheduling.
REQ-007 run_stop  input  1  one-cycle pulse; halts scheduling.
REQ-008 cfg_wr  input  1  one-cycle configuration write strobe.
REQ-009 cfg_ch  input  CH_W  channel addressed by cfg_wr.
REQ-010 cfg_en  input  1  channel enable value written.
REQ-011 cfg_type  input  1  channel rate type written (0 = type0, 1 = type2).
REQ-012 gen_ready  input  1  downstream accepts gen_valid beat.
REQ-013 gen_valid  output  1  data-generation grant for gen_ch.
REQ-014 gen_ch  output  CH_W  channel owning the grant.
REQ-015 slot_wrap  output  1  one-cycle pulse when slot NUM_CH-1 is evaluated.
REQ-016 running  output  1  high in RUN or STALL state.

Function
REQ-017 FSM states IDLE, RUN, STALL; IDLE after reset.
REQ-018 IDLE -> RUN on run_start; RUN -> IDLE on run_stop; run_start and run_stop together: run_stop wins.
REQ-019 RUN: slot pointer evaluates one channel per cycle, increments by 1, wraps NUM_CH-1 -> 0.
REQ-020 Rate constants: type0 X=9, Y=74984; type2 X=7, Y=9373.
REQ-021 Evaluated enabled channel: if acc >= Y, register gen_valid=1, gen_ch=slot, acc <= acc - Y; else acc <= acc + X, gen_valid=0.
REQ-022 Disabled channel: slot consumed, acc unchanged, gen_valid=0.
REQ-023 Latency: gen_valid/gen_ch registered, valid the cycle after slot evaluation.
REQ-024 gen_valid=1 and gen_ready=0 at an edge: RUN -> STALL; gen_valid, gen_ch, slot pointer, all accumulators frozen.
REQ-025 STALL -> RUN on the edge where gen_ready=1; beat completes, evaluation resumes at the next slot.
REQ-026 run_stop during STALL: held beat still completes on gen_ready, then IDLE.
REQ-027 Entering IDLE: gen_valid=0 once no beat is pending; slot pointer and accumulators retained.
REQ-028 cfg_wr accepted in any state: writes en/type for cfg_ch, clears that acc to 0.
REQ-029 cfg_wr to the channel evaluated in the same cycle: config wins, no grant that slot.
REQ-030 Accumulator arithmetic unsigned ACC_W bits; acc never exceeds Y+X-1, so no wrap.
REQ-031 slot_wrap pulses only for evaluations in RUN, not in STALL or IDLE.

Reset
REQ-032 On rst: state IDLE, slot pointer 0, all acc 0, all channels disabled, type 0.
REQ-033 On rst: gen_valid 0, gen_ch 0, slot_wrap 0, running 0.
REQ-034 rst mid-stall discards the pending beat without handshake.

Structure
REQ-035 Rate constants X/Y per type, FSM state encoding, default NUM_CH in shared package odu_pkg.
REQ-036 Per-channel rate step is sub-module odu_rate_step: inputs acc, type; outputs next acc, gen flag.

Verification
REQ-037 ch0 type2 enabled only, gen_ready=1, run: 1340th ch0 evaluation -> gen_valid=1, gen_ch=0, acc 0; next grant at 2680th.
REQ-038 ch3 type0 only: 8333rd ch3 evaluation -> gen_valid, gen_ch=3, acc=4.
REQ-039 Grant pending with gen_ready=0 for 5 cycles -> gen_valid/gen_ch held 5 cycles, slot pointer frozen, no slot_wrap.
REQ-040 cfg_wr ch2 on ch2's slot with acc=9373 -> no grant, acc=0.
REQ-041 run_stop during STALL -> beat held until gen_ready, then IDLE, running=0.
REQ-042 rst mid-STALL -> gen_valid=0 immediately, all acc 0, IDLE.
